// File: rtl/mac_accum.sv
// Burst multiply-accumulate: operand beats feed an external 8x8 multiplier through
// registered operands; products are summed with saturation and the result is held until taken.
module mac_accum #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mult_a,
  output logic [7:0]       mult_b,
  input  logic [16:0]      mult_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [LEN_W-1:0] out_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // ready never depends on valid, and a producer holds its payload until the transfer.

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       opa_q, opb_q;
  logic             s1_valid_q, s1_last_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             unused_p16;

  // The external multiplier cannot exceed 16 bits for 8x8 operands; bit 16 is ignored.
  assign unused_p16 = mult_p[16];

  assign accept = in_valid && (state_q == ST_ACC);
  assign sum    = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, mult_p[15:0]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    if (s1_valid_q) begin
      if (ovf_q || sum[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
      count_d = count_q + LEN_W'(1);
    end

    case (state_q)
      ST_ACC: begin
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (s1_valid_q && s1_last_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Taking the result also clears the accumulator for the next burst.
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      opa_q      <= '0;
      opb_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      opa_q      <= accept ? in_a : opa_q;
      opb_q      <= accept ? in_b : opb_q;
      s1_valid_q <= accept;
      s1_last_q  <= accept && in_last;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign mult_a    = opa_q;
  assign mult_b    = opb_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: hand-computed burst results go into an expected queue,
// a monitor pops and compares each result handshake; side checks cover timing and hold.
module tb_mac_accum;
  localparam int ACC_W = 24;
  localparam int LEN_W = 8;
  localparam int RES_W = 1 + LEN_W + ACC_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic [7:0]       mult_a;
  logic [7:0]       mult_b;
  logic [16:0]      mult_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic [LEN_W-1:0] out_count;
  logic [1:0]       dbg_state;
  logic             p16_force;

  logic [RES_W-1:0] exp_q[$];
  int               total_cnt = 0;
  int               pass_cnt  = 0;

  mac_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  // External combinational multiplier; bit 16 can be forced to show it is ignored.
  assign mult_p = {p16_force, 16'(mult_a * mult_b)};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Driver tasks: inputs change 1ns after a rising edge.
  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: compares each result as it is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {out_ovf, out_count, out_acc}, 0);
      end else begin
        logic [RES_W-1:0] e;
        e = exp_q.pop_front();
        check("res_acc", out_acc, e[ACC_W-1:0]);
        check("res_count", out_count, e[ACC_W+LEN_W-1:ACC_W]);
        check("res_ovf", out_ovf, e[RES_W-1]);
      end
    end
  end

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    p16_force = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mult_a", mult_a, 0);
    check("rst_mult_b", mult_b, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_count", out_count, 0);
    check("rst_state", dbg_state, 0);

    // Single max beat, latency accept -> out_valid is two edges
    exp_q.push_back({1'b0, 8'd1, 24'd65025});
    drive_beat(8'd255, 8'd255, 1'b1);
    check("lat_mult_a", mult_a, 255);
    check("lat_mult_b", mult_b, 255);
    check("lat_valid_n1", out_valid, 0);
    check("lat_ready_n1", in_ready, 0);
    @(posedge clk); #1;
    check("lat_valid_n2", out_valid, 1);
    drain();

    // Back-to-back burst: 6 + 20 + 42 = 68
    exp_q.push_back({1'b0, 8'd3, 24'd68});
    drive_beat(8'd2, 8'd3, 1'b0);
    check("b2b_ready1", in_ready, 1);
    drive_beat(8'd4, 8'd5, 1'b0);
    check("b2b_ready2", in_ready, 1);
    drive_beat(8'd6, 8'd7, 1'b1);
    check("b2b_ready_low", in_ready, 0);
    drain();

    // 300 x 65025 saturates 24 bits; count wraps to 44
    exp_q.push_back({1'b1, 8'd44, 24'hFFFFFF});
    for (int i = 0; i < 300; i++) drive_beat(8'd255, 8'd255, i == 299);
    drain();

    // Hold with out_ready low while inputs toggle
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'd1, 24'd30});
    drive_beat(8'd5, 8'd6, 1'b1);
    wait_valid("hold_valid");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 8'($urandom_range(1, 255));
      in_b     = 8'($urandom_range(1, 255));
      in_last  = 1'b1;
      @(posedge clk); #1;
      check("hold_acc", out_acc, 30);
      check("hold_count", out_count, 1);
      check("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_ready", in_ready, 1);
    check("release_acc", out_acc, 0);
    check("release_count", out_count, 0);
    check("release_valid", out_valid, 0);

    // Reset mid-burst discards the partial sum
    exp_q.push_back({1'b0, 8'd1, 24'd9});
    drive_beat(8'd10, 8'd10, 1'b0);
    drive_beat(8'd10, 8'd10, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_acc", out_acc, 0);
    check("midrst_count", out_count, 0);
    check("midrst_mult_a", mult_a, 0);
    drive_beat(8'd3, 8'd3, 1'b1);
    drain();

    // Zero product, and product bit 16 ignored
    exp_q.push_back({1'b0, 8'd1, 24'd0});
    drive_beat(8'd0, 8'd255, 1'b1);
    drain();
    p16_force = 1'b1;
    exp_q.push_back({1'b0, 8'd1, 24'd0});
    drive_beat(8'd0, 8'd255, 1'b1);
    drain();
    exp_q.push_back({1'b0, 8'd1, 24'd4});
    drive_beat(8'd2, 8'd2, 1'b1);
    drain();
    p16_force = 1'b0;

    // Reset in HOLD dominates a simultaneous output handshake
    out_ready = 1'b0;
    drive_beat(8'd7, 8'd7, 1'b1);
    wait_valid("rsthold_valid");
    check("rsthold_acc_before", out_acc, 49);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rsthold_out_valid", out_valid, 0);
    check("rsthold_acc", out_acc, 0);
    check("rsthold_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
